// File: rtl/core_pkg.sv
// Shared core definitions used by the writeback stage.
// Holds the opcode and load-funct3 encodings and the buffered writeback
// entry type. The entry data field is sized for the widest datapath
// (RV64); narrower instances zero-extend into it.
package core_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam int unsigned XLEN_MAX = 64;

  typedef struct packed {
    logic [4:0]          rd;
    logic [XLEN_MAX-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/writeback_buffered_if.sv
// Bus bundle for writeback_buffered.
// Carries the upstream valid/ready retire handshake with its operands, the
// register-file write port (grant-driven drain), the forwarding lookup port
// and the occupancy count.
//   slave  : view taken by the writeback stage
//   master : view taken by the surrounding pipeline / testbench
interface writeback_buffered_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2
);
  localparam int unsigned OFFW = $clog2(XLEN / 8);
  localparam int unsigned CW   = $clog2(DEPTH) + 1;

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [6:0]      in_opcode;
  logic [4:0]      in_rd;
  logic [2:0]      in_funct3;
  logic [OFFW-1:0] in_addr_lo;
  logic [XLEN-1:0] in_mem_res;
  logic [XLEN-1:0] in_alu_res;
  logic            rf_grant;
  logic            wb_enable;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic [4:0]      fwd_rs;
  logic            fwd_hit;
  logic [XLEN-1:0] fwd_data;
  logic [CW-1:0]   count;

  modport slave (
    input  in_valid, in_pc, in_opcode, in_rd, in_funct3, in_addr_lo,
           in_mem_res, in_alu_res, rf_grant, fwd_rs,
    output in_ready, wb_enable, wb_rd, wb_data, fwd_hit, fwd_data, count
  );

  modport master (
    output in_valid, in_pc, in_opcode, in_rd, in_funct3, in_addr_lo,
           in_mem_res, in_alu_res, rf_grant, fwd_rs,
    input  in_ready, wb_enable, wb_rd, wb_data, fwd_hit, fwd_data, count
  );

endinterface

// File: rtl/load_align.sv
// Load data formatter (combinational).
// Shifts the naturally aligned memory word right by the byte offset, then
// sign/zero-extends according to funct3. RV64-only widths (LWU, LD) and
// unknown funct3 codes yield zero.
//   i_funct3  : load width/sign selector
//   i_addr_lo : byte offset inside the aligned word/doubleword
//   i_mem_res : aligned memory data
//   o_data    : formatted load result
module load_align
  import core_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  localparam int unsigned OFFW = $clog2(XLEN / 8)
) (
  input  logic [2:0]      i_funct3,
  input  logic [OFFW-1:0] i_addr_lo,
  input  logic [XLEN-1:0] i_mem_res,
  output logic [XLEN-1:0] o_data
);

  logic [XLEN-1:0] w_shifted;

  assign w_shifted = i_mem_res >> {i_addr_lo, 3'b000};

  always_comb begin
    o_data = '0;
    case (i_funct3)
      F3_LB:  o_data = XLEN'(signed'(w_shifted[7:0]));
      F3_LH:  o_data = XLEN'(signed'(w_shifted[15:0]));
      F3_LW:  o_data = XLEN'(signed'(w_shifted[31:0]));
      F3_LBU: o_data = XLEN'(w_shifted[7:0]);
      F3_LHU: o_data = XLEN'(w_shifted[15:0]);
      F3_LWU: o_data = (XLEN == 64) ? XLEN'(w_shifted[31:0]) : '0;
      F3_LD:  o_data = (XLEN == 64) ? w_shifted : '0;
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/writeback_buffered.sv
// Buffered writeback stage between memory stage and register-file port.
// Formats the retiring result (load alignment/extension, pc+4 link for
// JAL/JALR, ALU pass-through), drops writes that target x0 and stores /
// branches, and queues the rest in a DEPTH-entry in-order FIFO drained one
// entry per rf_grant. A lookup port lets decode bypass buffered results.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : handshake, write port, forwarding and count (slave modport)
module writeback_buffered
  import core_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2
) (
  input logic                clock,
  input logic                reset,
  writeback_buffered_if.slave bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  wb_entry_t       r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic [XLEN-1:0] w_load_data;
  logic [XLEN-1:0] w_result;
  logic            w_pop;
  logic            w_ready;
  logic            w_push;
  logic            w_keep;
  logic            w_fwd_hit;
  logic [XLEN-1:0] w_fwd_data;

  load_align #(.XLEN(XLEN)) u_load_align (
    .i_funct3  (bus.in_funct3),
    .i_addr_lo (bus.in_addr_lo),
    .i_mem_res (bus.in_mem_res),
    .o_data    (w_load_data)
  );

  always_comb begin
    w_result = bus.in_alu_res;
    if (bus.in_opcode == OP_LOAD) begin
      w_result = w_load_data;
    end else if (bus.in_opcode == OP_JAL || bus.in_opcode == OP_JALR) begin
      w_result = bus.in_pc + XLEN'(4);
    end
  end

  assign w_keep  = (bus.in_rd != 5'd0) && (bus.in_opcode != OP_STORE) &&
                   (bus.in_opcode != OP_BRANCH);
  assign w_pop   = (r_count != '0) && bus.rf_grant;
  // A full buffer still accepts when the head leaves in the same cycle.
  assign w_ready = (r_count < DEPTH_C) || w_pop;
  assign w_push  = bus.in_valid && w_ready && w_keep;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= '{rd: bus.in_rd, data: XLEN_MAX'(w_result)};
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Walk entries oldest to youngest so the last match (youngest) wins.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    if (bus.fwd_rs != 5'd0) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if ((CW'(i) < r_count) &&
            (r_mem[r_rd_ptr + PW'(i)].rd == bus.fwd_rs)) begin
          w_fwd_hit  = 1'b1;
          w_fwd_data = r_mem[r_rd_ptr + PW'(i)].data[XLEN-1:0];
        end
      end
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.wb_enable = (r_count != '0);
  assign bus.wb_rd     = r_mem[r_rd_ptr].rd;
  assign bus.wb_data   = r_mem[r_rd_ptr].data[XLEN-1:0];
  assign bus.fwd_hit   = w_fwd_hit;
  assign bus.fwd_data  = w_fwd_data;
  assign bus.count     = r_count;

endmodule

// File: tb/tb_writeback_buffered.sv
// Directed testbench for writeback_buffered: RV32 and RV64 instances.
module tb_writeback_buffered;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  writeback_buffered_if #(.XLEN(32), .DEPTH(2)) b32 ();
  writeback_buffered_if #(.XLEN(64), .DEPTH(2)) b64 ();

  writeback_buffered #(.XLEN(32), .DEPTH(2)) u32 (
    .clock (clk),
    .reset (rst_n),
    .bus   (b32.slave)
  );

  writeback_buffered #(.XLEN(64), .DEPTH(2)) u64 (
    .clock (clk),
    .reset (rst_n),
    .bus   (b64.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle32();
    b32.in_valid   = 1'b0;
    b32.in_pc      = '0;
    b32.in_opcode  = 7'b0010011;
    b32.in_rd      = '0;
    b32.in_funct3  = '0;
    b32.in_addr_lo = '0;
    b32.in_mem_res = '0;
    b32.in_alu_res = '0;
  endtask

  task automatic drive32(input logic [6:0] op, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [1:0] lo,
                         input logic [31:0] mem, input logic [31:0] alu,
                         input logic [31:0] pc);
    b32.in_valid   = 1'b1;
    b32.in_opcode  = op;
    b32.in_funct3  = f3;
    b32.in_rd      = rd;
    b32.in_addr_lo = lo;
    b32.in_mem_res = mem;
    b32.in_alu_res = alu;
    b32.in_pc      = pc;
  endtask

  task automatic drive64(input logic [2:0] f3, input logic [4:0] rd,
                         input logic [2:0] lo, input logic [63:0] mem);
    b64.in_valid   = 1'b1;
    b64.in_opcode  = 7'b0000011;
    b64.in_funct3  = f3;
    b64.in_rd      = rd;
    b64.in_addr_lo = lo;
    b64.in_mem_res = mem;
    b64.in_alu_res = '0;
    b64.in_pc      = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle32();
    b32.rf_grant = 1'b0;
    b32.fwd_rs   = 5'd5;
    b64.in_valid = 1'b0;
    b64.in_pc = '0; b64.in_opcode = '0; b64.in_rd = '0; b64.in_funct3 = '0;
    b64.in_addr_lo = '0; b64.in_mem_res = '0; b64.in_alu_res = '0;
    b64.rf_grant = 1'b0;
    b64.fwd_rs   = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (b32.wb_enable !== 1'b0) begin errors++; $display("FAIL reset_wb_enable got %b exp 0", b32.wb_enable); end
    checks++;
    if (b32.count !== 2'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", b32.count); end
    checks++;
    if (b32.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", b32.in_ready); end
    checks++;
    if (b32.wb_rd !== 5'd0 || b32.wb_data !== 32'h0) begin
      errors++; $display("FAIL reset_head got rd=%0d data=%h exp rd=0 data=0", b32.wb_rd, b32.wb_data);
    end
    checks++;
    if (b32.fwd_hit !== 1'b0 || b32.fwd_data !== 32'h0) begin
      errors++; $display("FAIL reset_fwd got hit=%b data=%h exp 0/0", b32.fwd_hit, b32.fwd_data);
    end
  endtask

  task automatic test_load();
    @(negedge clk);
    b32.rf_grant = 1'b1;
    drive32(7'b0000011, 3'b000, 5'd5, 2'd2, 32'h80FF7F01, 32'h0, 32'h0);
    @(negedge clk);
    checks++;
    if (b32.wb_enable !== 1'b1 || b32.wb_rd !== 5'd5 || b32.wb_data !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL lb got en=%b rd=%0d data=%h exp 1/5/ffffffff", b32.wb_enable, b32.wb_rd, b32.wb_data);
    end
    drive32(7'b0000011, 3'b100, 5'd5, 2'd2, 32'h80FF7F01, 32'h0, 32'h0);
    @(negedge clk);
    checks++;
    if (b32.wb_data !== 32'h000000FF || b32.count !== 2'd1) begin
      errors++; $display("FAIL lbu got data=%h count=%0d exp 000000ff/1", b32.wb_data, b32.count);
    end
    drive32(7'b0000011, 3'b101, 5'd5, 2'd2, 32'h80FF7F01, 32'h0, 32'h0);
    @(negedge clk);
    checks++;
    if (b32.wb_data !== 32'h000080FF) begin
      errors++; $display("FAIL lhu got data=%h exp 000080ff", b32.wb_data);
    end
    drive32(7'b0000011, 3'b011, 5'd5, 2'd0, 32'h12345678, 32'hAAAA5555, 32'h0);
    @(negedge clk);
    checks++;
    if (b32.wb_enable !== 1'b1 || b32.wb_data !== 32'h0) begin
      errors++; $display("FAIL ld_rv32 got en=%b data=%h exp 1/00000000", b32.wb_enable, b32.wb_data);
    end
    idle32();
    @(negedge clk);
    checks++;
    if (b32.count !== 2'd0 || b32.wb_enable !== 1'b0) begin
      errors++; $display("FAIL load_drain got count=%0d en=%b exp 0/0", b32.count, b32.wb_enable);
    end
  endtask

  task automatic test_jal_filter();
    b32.rf_grant = 1'b0;
    drive32(7'b1101111, 3'b000, 5'd1, 2'd0, 32'h0, 32'hDEAD, 32'h00001000);
    @(negedge clk);
    checks++;
    if (b32.wb_rd !== 5'd1 || b32.wb_data !== 32'h00001004 || b32.count !== 2'd1) begin
      errors++; $display("FAIL jal got rd=%0d data=%h count=%0d exp 1/00001004/1", b32.wb_rd, b32.wb_data, b32.count);
    end
    idle32();
    b32.rf_grant = 1'b1;
    @(negedge clk);
    b32.rf_grant = 1'b0;
    drive32(7'b0100011, 3'b010, 5'd3, 2'd0, 32'h0, 32'h77, 32'h0);
    checks++;
    if (b32.in_ready !== 1'b1) begin errors++; $display("FAIL store_ready got %b exp 1", b32.in_ready); end
    @(negedge clk);
    checks++;
    if (b32.count !== 2'd0 || b32.wb_enable !== 1'b0) begin
      errors++; $display("FAIL store_drop got count=%0d en=%b exp 0/0", b32.count, b32.wb_enable);
    end
    drive32(7'b0010011, 3'b000, 5'd0, 2'd0, 32'h0, 32'h5, 32'h0);
    @(negedge clk);
    checks++;
    if (b32.count !== 2'd0 || b32.wb_enable !== 1'b0) begin
      errors++; $display("FAIL x0_drop got count=%0d en=%b exp 0/0", b32.count, b32.wb_enable);
    end
    drive32(7'b1100011, 3'b000, 5'd8, 2'd0, 32'h0, 32'h9, 32'h0);
    @(negedge clk);
    checks++;
    if (b32.count !== 2'd0) begin errors++; $display("FAIL branch_drop got count=%0d exp 0", b32.count); end
    idle32();
  endtask

  task automatic test_back_to_back();
    b32.rf_grant = 1'b0;
    drive32(7'b0110011, 3'b000, 5'd4, 2'd0, 32'h0, 32'h44, 32'h0);
    @(negedge clk);
    drive32(7'b0110011, 3'b000, 5'd6, 2'd0, 32'h0, 32'h66, 32'h0);
    @(negedge clk);
    drive32(7'b0110011, 3'b000, 5'd7, 2'd0, 32'h0, 32'h77, 32'h0);
    checks++;
    if (b32.count !== 2'd2 || b32.in_ready !== 1'b0) begin
      errors++; $display("FAIL full got count=%0d ready=%b exp 2/0", b32.count, b32.in_ready);
    end
    @(negedge clk);
    checks++;
    if (b32.count !== 2'd2 || b32.wb_rd !== 5'd4 || b32.wb_data !== 32'h44) begin
      errors++; $display("FAIL full_hold got count=%0d rd=%0d data=%h exp 2/4/44", b32.count, b32.wb_rd, b32.wb_data);
    end
    b32.rf_grant = 1'b1;
    #1;
    checks++;
    if (b32.in_ready !== 1'b1) begin errors++; $display("FAIL full_pop_ready got %b exp 1", b32.in_ready); end
    @(negedge clk);
    idle32();
    checks++;
    if (b32.count !== 2'd2 || b32.wb_rd !== 5'd6 || b32.wb_data !== 32'h66) begin
      errors++; $display("FAIL swap got count=%0d rd=%0d data=%h exp 2/6/66", b32.count, b32.wb_rd, b32.wb_data);
    end
    @(negedge clk);
    checks++;
    if (b32.count !== 2'd1 || b32.wb_rd !== 5'd7 || b32.wb_data !== 32'h77) begin
      errors++; $display("FAIL drain7 got count=%0d rd=%0d data=%h exp 1/7/77", b32.count, b32.wb_rd, b32.wb_data);
    end
    @(negedge clk);
    checks++;
    if (b32.count !== 2'd0) begin errors++; $display("FAIL drain_empty got count=%0d exp 0", b32.count); end
    b32.rf_grant = 1'b0;
  endtask

  task automatic test_rv64();
    b64.rf_grant = 1'b1;
    drive64(3'b011, 5'd2, 3'd0, 64'h8000000000000001);
    @(negedge clk);
    checks++;
    if (b64.wb_enable !== 1'b1 || b64.wb_data !== 64'h8000000000000001) begin
      errors++; $display("FAIL ld64 got en=%b data=%h exp 1/8000000000000001", b64.wb_enable, b64.wb_data);
    end
    drive64(3'b010, 5'd2, 3'd4, 64'h8000000000000000);
    @(negedge clk);
    checks++;
    if (b64.wb_data !== 64'hFFFFFFFF80000000) begin
      errors++; $display("FAIL lw64 got data=%h exp ffffffff80000000", b64.wb_data);
    end
    drive64(3'b110, 5'd2, 3'd4, 64'h8000000000000000);
    @(negedge clk);
    checks++;
    if (b64.wb_data !== 64'h0000000080000000) begin
      errors++; $display("FAIL lwu64 got data=%h exp 0000000080000000", b64.wb_data);
    end
    drive64(3'b000, 5'd2, 3'd7, 64'h7F00000000000000);
    @(negedge clk);
    checks++;
    if (b64.wb_data !== 64'h000000000000007F) begin
      errors++; $display("FAIL lb64_off7 got data=%h exp 000000000000007f", b64.wb_data);
    end
    b64.in_valid = 1'b0;
    @(negedge clk);
    b64.rf_grant = 1'b0;
  endtask

  task automatic test_forward();
    b32.rf_grant = 1'b0;
    drive32(7'b0110011, 3'b000, 5'd9, 2'd0, 32'h0, 32'h11, 32'h0);
    @(negedge clk);
    drive32(7'b0110011, 3'b000, 5'd9, 2'd0, 32'h0, 32'h22, 32'h0);
    @(negedge clk);
    idle32();
    b32.fwd_rs = 5'd9;
    #1;
    checks++;
    if (b32.fwd_hit !== 1'b1 || b32.fwd_data !== 32'h22) begin
      errors++; $display("FAIL fwd_young got hit=%b data=%h exp 1/22", b32.fwd_hit, b32.fwd_data);
    end
    b32.fwd_rs = 5'd0;
    #1;
    checks++;
    if (b32.fwd_hit !== 1'b0 || b32.fwd_data !== 32'h0) begin
      errors++; $display("FAIL fwd_x0 got hit=%b data=%h exp 0/0", b32.fwd_hit, b32.fwd_data);
    end
    b32.fwd_rs = 5'd12;
    #1;
    checks++;
    if (b32.fwd_hit !== 1'b0 || b32.fwd_data !== 32'h0) begin
      errors++; $display("FAIL fwd_miss got hit=%b data=%h exp 0/0", b32.fwd_hit, b32.fwd_data);
    end
    b32.fwd_rs = 5'd9;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    checks++;
    if (b32.count !== 2'd2) begin errors++; $display("FAIL pre_reset_count got %0d exp 2", b32.count); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (b32.wb_enable !== 1'b0 || b32.count !== 2'd0 || b32.fwd_hit !== 1'b0) begin
      errors++; $display("FAIL async_reset got en=%b count=%0d hit=%b exp 0/0/0", b32.wb_enable, b32.count, b32.fwd_hit);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (b32.in_ready !== 1'b1 || b32.wb_rd !== 5'd0 || b32.wb_data !== 32'h0) begin
      errors++; $display("FAIL post_reset got ready=%b rd=%0d data=%h exp 1/0/0", b32.in_ready, b32.wb_rd, b32.wb_data);
    end
    drive32(7'b0110011, 3'b000, 5'd11, 2'd0, 32'h0, 32'h5A, 32'h0);
    @(negedge clk);
    idle32();
    checks++;
    if (b32.count !== 2'd1 || b32.wb_rd !== 5'd11 || b32.wb_data !== 32'h5A || u32.r_mem[0].rd !== 5'd11) begin
      errors++; $display("FAIL first_accept got count=%0d rd=%0d data=%h mem0rd=%0d exp 1/11/5a/11",
                         b32.count, b32.wb_rd, b32.wb_data, u32.r_mem[0].rd);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_load();
    test_jal_filter();
    test_back_to_back();
    test_rv64();
    test_forward();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
